display_scheduler: RTL and testbench

Page sequencer and arbiter for the 8-digit seven-segment scoreboard. It decides which score page is on the tubes (combo, base score, bonus score, accuracy, mod, difficulty, level), handles auto-advance and player next/prev steps, and inserts a blank gap between pages. Transient alerts (e.g. "FULL COMBO", "MISS") pre-empt the page view for a fixed hold time. It sits between the game-state/input blocks and the scoreboard's page-select and blanking inputs.

---
 rtl/display_scheduler.sv | 130 +++++++++++++
 tb/tb_display_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: page sequencer/arbiter for the seven-segment scoreboard.
// Cycles score pages with blank gaps between them; timed alerts pre-empt the page view.
module display_scheduler #(
  parameter int TICK_DIV  = 100000,
  parameter int PAGE_MS   = 2000,
  parameter int GAP_MS    = 50,
  parameter int ALERT_MS  = 1000,
  parameter int NUM_PAGES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto_en,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       alert_req,
  input  logic [2:0] alert_code,
  output logic [2:0] page,
  output logic       blank,
  output logic       alert_active,
  output logic [2:0] alert_sel,
  output logic       page_changed
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DW = PAGE_MS > 1 ? $clog2(PAGE_MS) : 1;
  localparam int HM = GAP_MS > ALERT_MS ? GAP_MS : ALERT_MS;
  localparam int HW = HM > 1 ? $clog2(HM) : 1;
  typedef enum logic [1:0] {OFF, SHOW, GAP, ALERT} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [HW-1:0] hold, hold_n;
  logic [2:0] page_n, sel_n, pg_inc, pg_dec;
  logic ms_tick, step_next, step_prev, pc_n;
  always_comb begin
    ms_tick = presc == PW'(TICK_DIV - 1);
    step_next = btn_next & ~btn_prev;
    step_prev = btn_prev & ~btn_next;
    pg_inc = page == 3'(NUM_PAGES - 1) ? 3'd0 : page + 3'd1;
    pg_dec = page == 3'd0 ? 3'(NUM_PAGES - 1) : page - 3'd1;
    state_n = state;
    page_n = page;
    dwell_n = dwell;
    hold_n = hold;
    sel_n = alert_sel;
    pc_n = 1'b0;
    presc_n = ms_tick ? '0 : presc + 1'b1;
    case (state)
      OFF: begin
        state_n = SHOW;
        presc_n = '0;
        dwell_n = '0;
      end
      SHOW, GAP: begin
        if (alert_req) begin
          state_n = ALERT;
          sel_n = alert_code;
          presc_n = '0;
          hold_n = '0;
        end else if (step_next | step_prev) begin
          page_n = step_next ? pg_inc : pg_dec;
          pc_n = 1'b1;
          state_n = GAP;
          presc_n = '0;
          hold_n = '0;
        end else if (state == SHOW) begin
          if (ms_tick & auto_en) begin
            if (dwell == DW'(PAGE_MS - 1)) begin
              page_n = pg_inc;
              pc_n = 1'b1;
              state_n = GAP;
              hold_n = '0;
            end else dwell_n = dwell + 1'b1;
          end
        end else if (ms_tick) begin
          if (hold == HW'(GAP_MS - 1)) begin
            state_n = SHOW;
            dwell_n = '0;
            hold_n = '0;
          end else hold_n = hold + 1'b1;
        end
      end
      default: begin
        // a fresh request relatches the code and restarts the hold from zero
        if (alert_req) begin
          sel_n = alert_code;
          presc_n = '0;
          hold_n = '0;
        end else if (ms_tick) begin
          if (hold == HW'(ALERT_MS - 1)) begin
            state_n = GAP;
            hold_n = '0;
          end else hold_n = hold + 1'b1;
        end
      end
    endcase
    if (!en) begin
      state_n = OFF;
      page_n = '0;
      dwell_n = '0;
      hold_n = '0;
      presc_n = '0;
      sel_n = '0;
      pc_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      page <= '0;
      dwell <= '0;
      hold <= '0;
      presc <= '0;
      alert_sel <= '0;
      blank <= 1'b1;
      alert_active <= 1'b0;
      page_changed <= 1'b0;
    end else begin
      state <= state_n;
      page <= page_n;
      dwell <= dwell_n;
      hold <= hold_n;
      presc <= presc_n;
      alert_sel <= sel_n;
      blank <= state_n == OFF || state_n == GAP;
      alert_active <= state_n == ALERT;
      page_changed <= pc_n;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: vector table, multi-cycle corner sequences and a randomized
// run against a duration-based model of the page/gap/alert behaviour.
module tb_display_scheduler;
  localparam int TD = 4, PM = 5, GM = 2, AM = 3, NP = 7;
  localparam int M_OFF = 0, M_SHOW = 1, M_GAP = 2, M_ALERT = 3;
  logic clk = 1'b0, rst, en, auto_en, btn_next, btn_prev, alert_req;
  logic [2:0] alert_code, page, alert_sel;
  logic blank, alert_active, page_changed;
  wire [8:0] outs = {page, blank, alert_active, alert_sel, page_changed};
  int checks = 0, errors = 0, pcs = 0, n, b, h;
  int m_mode, m_page, m_t, m_dw, m_sel;
  bit m_pc;
  typedef struct {
    logic en, auto_en, bn, bp, ar;
    logic [2:0] code;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[12];

  display_scheduler #(.TICK_DIV(TD), .PAGE_MS(PM), .GAP_MS(GM), .ALERT_MS(AM), .NUM_PAGES(NP)) dut (
    .clk(clk), .rst(rst), .en(en), .auto_en(auto_en), .btn_next(btn_next), .btn_prev(btn_prev),
    .alert_req(alert_req), .alert_code(alert_code), .page(page), .blank(blank),
    .alert_active(alert_active), .alert_sel(alert_sel), .page_changed(page_changed));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pcs += int'(page_changed);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    alert_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; auto_en = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    alert_req = 1'b0; alert_code = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic gap_len(output int len);
    len = 0;
    for (int i = 0; i < 30 && blank; i++) begin
      len++;
      step();
    end
  endtask

  task automatic alert_len(output int len);
    len = 0;
    for (int i = 0; i < 40 && alert_active; i++) begin
      len++;
      step();
    end
  endtask

  task automatic show_len(output int len);
    logic [2:0] p0;
    p0 = page;
    len = 0;
    for (int i = 0; i < 40 && page == p0; i++) begin
      step();
      len++;
    end
  endtask

  function automatic vec_t mk(input int e, a, nx, pv, ar, c, pg, bl, aa, s, pc);
    vec_t v;
    v.en = e[0]; v.auto_en = a[0]; v.bn = nx[0]; v.bp = pv[0]; v.ar = ar[0]; v.code = 3'(c);
    v.exp = {3'(pg), bl[0], aa[0], 3'(s), pc[0]};
    return v;
  endfunction

  // reference: phases measured in elapsed cycles, pages in modular arithmetic
  task automatic model_step(input logic e, a, nx, pv, ar, input logic [2:0] code);
    bit tk, st;
    tk = (m_t % TD) == TD - 1;
    st = nx ^ pv;
    m_pc = 1'b0;
    if (!e) begin
      m_mode = M_OFF; m_page = 0; m_sel = 0; m_t = 0; m_dw = 0;
    end else if (m_mode == M_OFF) begin
      m_mode = M_SHOW; m_t = 0; m_dw = 0;
    end else if (m_mode == M_ALERT) begin
      if (ar) begin m_sel = int'(code); m_t = 0; end
      else if (m_t + 1 == AM * TD) begin m_mode = M_GAP; m_t = 0; end
      else m_t++;
    end else if (ar) begin
      m_mode = M_ALERT; m_sel = int'(code); m_t = 0;
    end else if (st) begin
      m_page = nx ? (m_page + 1) % NP : (m_page + NP - 1) % NP;
      m_pc = 1'b1; m_mode = M_GAP; m_t = 0;
    end else if (m_mode == M_SHOW) begin
      if (tk && a && m_dw + 1 == PM) begin
        m_page = (m_page + 1) % NP; m_pc = 1'b1; m_mode = M_GAP; m_t = 0;
      end else begin
        if (tk && a) m_dw++;
        m_t++;
      end
    end else if (m_t + 1 == GM * TD) begin
      m_mode = M_SHOW; m_t = 0; m_dw = 0;
    end else m_t++;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 6, 1, 0, 0, 1);
    tbl[2]  = mk(1, 0, 1, 1, 0, 0, 6, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 1, 5, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 0, 0, 6, 1, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    do_reset();
    chk("reset", outs, 9'b000_1_0_000_0);
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; auto_en = tbl[i].auto_en; btn_next = tbl[i].bn; btn_prev = tbl[i].bp;
      alert_req = tbl[i].ar; alert_code = tbl[i].code;
      step();
      chk($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    do_reset();
    pcs = 0;
    en = 1'b1; auto_en = 1'b1;
    step();
    chk("show_entry", {page, blank}, {3'd0, 1'b0});
    show_len(n);
    chk("auto_dwell", n, 20);
    chk("auto_page", page, 1);
    gap_len(b);
    chk("auto_gap", b, 8);
    chk("auto_pc_once", pcs, 1);

    auto_en = 1'b0;
    btn_next = 1'b1;
    step();
    chk("gap_first", {page, blank}, {3'd2, 1'b1});
    repeat (3) step();
    btn_next = 1'b1;
    step();
    chk("gap_restart_page", page, 3);
    gap_len(b);
    chk("gap_restart_len", b, 8);

    auto_en = 1'b1;
    repeat (12) step();
    alert_req = 1'b1; alert_code = 3'd5;
    step();
    chk("alert1", {alert_active, alert_sel, page, blank}, {1'b1, 3'd5, 3'd3, 1'b0});
    h = 1;
    repeat (5) begin step(); h += int'(alert_active); end
    chk("alert_pre", h, 6);
    alert_req = 1'b1; alert_code = 3'd2;
    step();
    chk("alert2_sel", alert_sel, 2);
    alert_len(h);
    chk("alert_hold", h, 12);
    chk("alert_exit", {page, blank}, {3'd3, 1'b1});
    gap_len(b);
    chk("alert_gap", b, 8);
    show_len(n);
    chk("alert_dwell_clr", n, 20);
    gap_len(b);
    chk("auto_gap2", b, 8);

    repeat (19) step();
    alert_req = 1'b1; alert_code = 3'd6; btn_next = 1'b1;
    step();
    chk("coinc_alert", {alert_active, alert_sel, page, page_changed}, {1'b1, 3'd6, 3'd4, 1'b0});
    alert_len(h);
    gap_len(b);
    repeat (19) step();
    btn_next = 1'b1;
    step();
    chk("btn_vs_auto", {page, page_changed}, {3'd5, 1'b1});
    step();
    chk("pc_single", {page, page_changed}, {3'd5, 1'b0});

    en = 1'b0;
    step();
    chk("gap_to_off", outs, 9'b000_1_0_000_0);
    en = 1'b1;
    step();
    btn_next = 1'b1;
    step();
    gap_len(b);
    chk("pre_rst", {page, blank}, {3'd1, 1'b0});
    #2 rst = 1'b1;
    #1 chk("async_rst", outs, 9'b000_1_0_000_0);
    rst = 1'b0;

    do_reset();
    m_mode = M_OFF; m_page = 0; m_t = 0; m_dw = 0; m_sel = 0; m_pc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 99) < 97;
      auto_en = $urandom_range(0, 9) < 8;
      btn_next = $urandom_range(0, 99) < 6;
      btn_prev = $urandom_range(0, 99) < 6;
      alert_req = $urandom_range(0, 99) < 3;
      alert_code = 3'($urandom_range(0, 7));
      @(posedge clk);
      model_step(en, auto_en, btn_next, btn_prev, alert_req, alert_code);
      #1;
      chk("rand", outs, {3'(m_page), m_mode == M_OFF || m_mode == M_GAP, m_mode == M_ALERT, 3'(m_sel), m_pc});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
